// File: rtl/cordic_polar_avg.sv
// Boxcar moving average of CORDIC radius/phase over 2^L samples, with peak |error|
// tracking and a valid/ready output register that flags overwritten results.
module cordic_polar_avg #(
    parameter int unsigned W = 7,
    parameter int unsigned L = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W:0]   r_in,
    input  logic signed [W:0]   phi_in,
    input  logic signed [W:0]   eps_in,
    input  logic                in_valid,
    input  logic                clear,
    input  logic                out_ready,
    output logic signed [W:0]   r_avg,
    output logic signed [W:0]   phi_avg,
    output logic signed [W:0]   eps_peak,
    output logic                out_valid,
    output logic                overrun
);

    localparam int unsigned N  = 1 << L;
    localparam int unsigned SW = W + 1 + L;
    localparam int unsigned CW = L + 1;
    localparam logic signed [W:0] EPS_MIN = {1'b1, {W{1'b0}}};
    localparam logic signed [W:0] EPS_MAX = {1'b0, {W{1'b1}}};

    logic signed [W:0]    r_win   [N];
    logic signed [W:0]    phi_win [N];
    logic signed [SW-1:0] r_sum;
    logic signed [SW-1:0] phi_sum;
    logic [CW-1:0]        cnt;

    logic                 accept;
    logic                 load;
    logic signed [SW-1:0] r_sum_upd;
    logic signed [SW-1:0] phi_sum_upd;
    logic [CW-1:0]        cnt_upd;
    logic signed [W:0]    eps_abs;

    // Incremental sums: add the incoming sample, drop the one falling off the window.
    always_comb begin
        accept      = in_valid && !clear;
        r_sum_upd   = r_sum
                    + $signed({{L{r_in[W]}}, r_in})
                    - $signed({{L{r_win[N-1][W]}}, r_win[N-1]});
        phi_sum_upd = phi_sum
                    + $signed({{L{phi_in[W]}}, phi_in})
                    - $signed({{L{phi_win[N-1][W]}}, phi_win[N-1]});
        cnt_upd     = (cnt == CW'(N)) ? cnt : cnt + CW'(1);
        load        = accept && (cnt_upd == CW'(N));
        eps_abs     = eps_in;
        if (eps_in == EPS_MIN) begin
            eps_abs = EPS_MAX;
        end else if (eps_in[W]) begin
            eps_abs = -eps_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                r_win[i]   <= '0;
                phi_win[i] <= '0;
            end
            r_sum     <= '0;
            phi_sum   <= '0;
            cnt       <= '0;
            r_avg     <= '0;
            phi_avg   <= '0;
            eps_peak  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                r_win[i]   <= '0;
                phi_win[i] <= '0;
            end
            r_sum     <= '0;
            phi_sum   <= '0;
            cnt       <= '0;
            r_avg     <= '0;
            phi_avg   <= '0;
            eps_peak  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                r_win[0]   <= r_in;
                phi_win[0] <= phi_in;
                for (int i = 1; i < N; i++) begin
                    r_win[i]   <= r_win[i-1];
                    phi_win[i] <= phi_win[i-1];
                end
                r_sum   <= r_sum_upd;
                phi_sum <= phi_sum_upd;
                cnt     <= cnt_upd;
                if (eps_abs > eps_peak) begin
                    eps_peak <= eps_abs;
                end
            end
            // Slicing bits [L+W:L] is the arithmetic shift by L, i.e. floor division.
            if (load) begin
                r_avg     <= r_sum_upd[L +: W+1];
                phi_avg   <= phi_sum_upd[L +: W+1];
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_polar_avg.sv
// Randomized and directed checks of cordic_polar_avg against a queue-based
// reference model (W=7, L=2).
module tb_cordic_polar_avg;

    localparam int unsigned W = 7;
    localparam int unsigned L = 2;
    localparam int N = 4;

    logic              clk;
    logic              reset;
    logic signed [W:0] r_in;
    logic signed [W:0] phi_in;
    logic signed [W:0] eps_in;
    logic              in_valid;
    logic              clear;
    logic              out_ready;
    logic signed [W:0] r_avg;
    logic signed [W:0] phi_avg;
    logic signed [W:0] eps_peak;
    logic              out_valid;
    logic              overrun;

    int total;
    int bad;

    // Reference model state: newest sample at the queue front.
    int m_rq[$];
    int m_pq[$];
    int m_cnt;
    int m_r_avg;
    int m_p_avg;
    int m_eps;
    bit m_valid;
    bit m_ov;

    cordic_polar_avg #(.W(W), .L(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .r_in      (r_in),
        .phi_in    (phi_in),
        .eps_in    (eps_in),
        .in_valid  (in_valid),
        .clear     (clear),
        .out_ready (out_ready),
        .r_avg     (r_avg),
        .phi_avg   (phi_avg),
        .eps_peak  (eps_peak),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    function automatic int sum_q(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic model_clear();
        m_rq.delete();
        m_pq.delete();
        for (int i = 0; i < N; i++) begin
            m_rq.push_back(0);
            m_pq.push_back(0);
        end
        m_cnt = 0; m_r_avg = 0; m_p_avg = 0; m_eps = 0;
        m_valid = 1'b0; m_ov = 1'b0;
    endtask

    task automatic model_edge(input bit iv, input bit clr, input bit rdy,
                              input int r, input int p, input int e);
        bit loaded = 1'b0;
        int ea;
        if (clr) begin
            model_clear();
            return;
        end
        if (iv) begin
            m_rq.push_front(r); void'(m_rq.pop_back());
            m_pq.push_front(p); void'(m_pq.pop_back());
            if (m_cnt < N) m_cnt++;
            ea = (e < 0) ? -e : e;
            if (ea > 127) ea = 127;
            if (ea > m_eps) m_eps = ea;
            if (m_cnt == N) begin
                loaded = 1'b1;
                if (m_valid && !rdy) m_ov = 1'b1;
                m_valid = 1'b1;
                m_r_avg = floor_div(sum_q(m_rq));
                m_p_avg = floor_div(sum_q(m_pq));
            end
        end
        if (!loaded && m_valid && rdy) m_valid = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".r_avg"},     int'(r_avg),     m_r_avg);
        check({tag, ".phi_avg"},   int'(phi_avg),   m_p_avg);
        check({tag, ".eps_peak"},  int'(eps_peak),  m_eps);
        check({tag, ".out_valid"}, int'(out_valid), int'(m_valid));
        check({tag, ".overrun"},   int'(overrun),   int'(m_ov));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare against the model.
    task automatic step(input string tag, input bit iv, input bit clr, input bit rdy,
                        input int r, input int p, input int e);
        in_valid  = iv;
        clear     = clr;
        out_ready = rdy;
        r_in      = (W+1)'(r);
        phi_in    = (W+1)'(p);
        eps_in    = (W+1)'(e);
        @(posedge clk);
        #1;
        model_edge(iv, clr, rdy, r, p, e);
        compare_all(tag);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        r_in = '0; phi_in = '0; eps_in = '0;
        model_clear();
        #2;
        compare_all("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Fill and slide
        step("fill1", 1, 0, 1, 10, 0, 0);
        step("fill2", 1, 0, 1, 20, 0, 0);
        step("fill3", 1, 0, 1, 30, 0, 0);
        check("warmup_valid", int'(out_valid), 0);
        step("fill4", 1, 0, 1, 40, 0, 0);
        check("fill_valid", int'(out_valid), 1);
        check("fill_r", int'(r_avg), 25);
        step("slide", 1, 0, 1, 50, 0, 0);
        check("slide_r", int'(r_avg), 35);
        for (int i = 0; i < 4; i++) step("neg_full", 1, 0, 1, -128, 0, 0);
        check("neg_full_r", int'(r_avg), -128);

        // Negative phase rounding toward -inf
        step("phi1", 1, 0, 1, 0, -1, 0);
        step("phi2", 1, 0, 1, 0, -2, 0);
        step("phi3", 1, 0, 1, 0, -3, 0);
        step("phi4", 1, 0, 1, 0, -3, 0);
        check("phi_floor", int'(phi_avg), -3);

        // Consume+load every cycle raises no overrun
        step("ovclr", 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("stream", 1, 0, 1, i * 7, -i, 0);
        check("stream_no_ov", int'(overrun), 0);

        // Back-pressure
        step("bp1", 1, 0, 0, 60, 5, 0);
        step("bp2", 1, 0, 0, 70, 6, 0);
        check("bp_overrun", int'(overrun), 1);
        step("bp_hold", 0, 0, 0, 0, 0, 0);
        check("bp_sticky", int'(overrun), 1);
        step("bp_drain", 0, 0, 1, 0, 0, 0);
        check("bp_drained", int'(out_valid), 0);
        check("bp_drained_ov", int'(overrun), 1);
        step("bp_load", 1, 0, 0, 80, 7, 0);
        step("bp_same", 1, 0, 1, 90, 8, 0);
        check("bp_same_valid", int'(out_valid), 1);

        // Error peak
        step("eclr", 0, 1, 1, 0, 0, 0);
        step("eps1", 1, 0, 1, 0, 0, -5);
        step("eps2", 1, 0, 1, 0, 0, 3);
        check("eps_peak5", int'(eps_peak), 5);
        step("eps3", 1, 0, 1, 0, 0, -128);
        check("eps_sat", int'(eps_peak), 127);

        // Clear wins over a simultaneous sample
        step("clr_iv", 1, 1, 1, 99, 9, 9);
        check("clr_r", int'(r_avg), 0);
        for (int i = 0; i < 3; i++) step("post_clr", 1, 0, 1, 11 * i, i, 0);
        check("post_clr_valid", int'(out_valid), 0);

        // Asynchronous reset mid-window
        step("pre_rst", 1, 0, 1, 44, 4, 12);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        compare_all("async_rst");
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("rewarm", 1, 0, 1, 20, 4, 0);
        check("rewarm_valid", int'(out_valid), 0);
        step("rewarm4", 1, 0, 1, 20, 4, 0);
        check("rewarm_r", int'(r_avg), 20);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 1) == 1),
                 int'($signed(8'($urandom))),
                 int'($signed(8'($urandom))),
                 int'($signed(8'($urandom))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_polar_avg.md
# cordic_polar_avg

Downstream stage of the CORDIC rectangular-to-polar core. It takes each radius/phase/error result and keeps a boxcar moving average of radius and phase over the last 2^L accepted samples. It also tracks the peak absolute error since the last clear. Results go to the consumer through a valid/ready output register. The CORDIC core cannot be back-pressured, so the block flags an overrun when an unconsumed result is overwritten.

## Interface
Parameters:
- W, 7: data MSB index; all data ports are W+1 bits, signed two's complement.
- L, 2: log2 of the averaging window; window depth N = 2^L, L >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- r_in  input  [W:0] signed  radius from the CORDIC core.
- phi_in  input  [W:0] signed  phase from the CORDIC core.
- eps_in  input  [W:0] signed  error term from the CORDIC core.
- in_valid  input  1  r_in/phi_in/eps_in carry a new result this cycle.
- clear  input  1  synchronous flush of window, sums, counters and flags.
- out_ready  input  1  consumer accepts the output this cycle.
- r_avg  output  [W:0] signed  windowed mean radius.
- phi_avg  output  [W:0] signed  windowed mean phase.
- eps_peak  output  [W:0] signed  max |eps_in| since reset/clear, non-negative.
- out_valid  output  1  r_avg/phi_avg hold an unconsumed result.
- overrun  output  1  sticky; a result was overwritten before it was consumed.

## Operation
- A sample is accepted on an edge where in_valid=1 and clear=0.
- Window: two N-deep shift registers (r, phi). On accept, the new sample enters and the oldest leaves.
- Running sums are W+1+L bits signed. On accept: sum_next = sum + new - oldest. Sums are never recomputed from the window.
- Empty window slots hold 0, so partial sums during fill are exact.
- Fill counter: 0..N, saturates at N, increments on each accept.
- Result: avg = sum_next >>> L (arithmetic shift, rounds toward -inf). It is loaded into r_avg/phi_avg on the accept edge, but only when the counter after increment equals N.
- No output is produced during warm-up: the first N-1 accepts after reset/clear leave out_valid=0.
- eps_peak: on each accept, compare |eps_in| with the current value and keep the larger. |-2^W| saturates to 2^W-1.
- Phase is averaged arithmetically with no unwrap. A window straddling ±full-scale gives a meaningless mean; this is a documented limitation.
- Output handshake:
  - out_valid&&out_ready consumes the result; out_valid clears next edge unless a new result loads on that same edge.
  - A load on the same edge as a consume leaves out_valid=1 and sets no overrun.
  - A load while out_valid=1 and out_ready=0 overwrites the outputs and sets overrun=1.
- clear=1:
  - Zeros window, sums, fill counter, r_avg, phi_avg, eps_peak, out_valid and overrun on that edge.
  - clear wins over a simultaneous in_valid; that sample is dropped.
- No state machine beyond the fill counter: the block is in WARMUP (count<N) or RUN (count=N). Only reset or clear returns it to WARMUP.

## Timing
- Reset (reset=0, asynchronous): every register is 0, including all outputs, window and sums. Outputs stay 0 while reset=0.
- Release is synchronous to the next clk edge. The first accept can occur on the first edge with reset=1.
- Latency: a sample accepted at edge k is reflected in r_avg/phi_avg/eps_peak immediately after edge k (one register stage). The output path is fully registered.
- Throughput: one sample per cycle, sustained indefinitely. in_valid may stay high continuously.
- Reset mid-operation: all partial window contents are lost, and a new warm-up of N samples is required.
- Outputs are stable while out_valid=1 and out_ready=0, except when a newer result overwrites them (overrun).

## Test plan
All scenarios use W=7, L=2.
- Fill: after reset, feed r=10,20,30,40 and phi=0 on consecutive cycles -> out_valid first rises after the 4th edge, r_avg=25, phi_avg=0. No out_valid after samples 1-3.
- Slide: continue with r=50 -> r_avg=35 (20+30+40+50=140, >>>2). Feed r=-128 four times -> r_avg=-128 with no sum overflow.
- Negative rounding: phi=-1,-2,-3,-3 -> phi_avg=-3 (sum -9 >>> 2 = -3, floor).
- Back-pressure: out_ready=0 with a full window; accept two samples -> outputs show the second result, overrun=1 and it stays 1. Raise out_ready with in_valid=0 -> out_valid=0 next edge, overrun still 1. Consume and load on the same edge -> out_valid stays 1, no new overrun.
- Error peak: eps_in=-5 then 3 -> eps_peak=5; eps_in=-128 -> eps_peak=127.
- Clear/reset: assert clear together with in_valid (r=99) -> all outputs 0 and the sample dropped; 3 more samples -> no out_valid. Drive reset=0 asynchronously mid-window -> outputs 0 before the next clk edge; a 4-sample warm-up is needed again.
